// File: rtl/dly_pkg.sv
// Shared types and helpers for the programmable delay line.
// Fill-state encoding and delay clamping.
package dly_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } dly_state_e;

    function automatic int clamp_delay(input int d, input int max_d);
        return (d > max_d) ? max_d : d;
    endfunction

endpackage

// File: rtl/dly_stage.sv
// One {valid,data} storage stage of the delay line.
// Shifts on en; clr drops the valid bit, data is kept.
module dly_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_data,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q_data,
    output logic             q_valid
);

    // Stage register: shift on en, invalidate on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data  <= '0;
            q_valid <= 1'b0;
        end else if (en) begin
            q_data  <= d_data;
            q_valid <= d_valid & ~clr;
        end else if (clr) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/programmable_delay_line.sv
// Runtime-programmable delay line with valid tracking.
// Fill FSM gates out_valid until d_active fresh samples are held.
module programmable_delay_line
    import dly_pkg::*;
#(
    parameter  int WIDTH         = 8,
    parameter  int MAX_DEPTH     = 8,
    parameter  int DEFAULT_DELAY = 1,
    localparam int DW            = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic [DW-1:0]    delay_sel,
    input  logic             load,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             filled,
    output logic             cfg_err,
    output logic [DW-1:0]    d_active
);

    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] DEF_D = DW'(DEFAULT_DELAY);
    localparam logic [DW-1:0] ONE   = DW'(1);

    logic [WIDTH-1:0] st_data  [MAX_DEPTH];
    logic             st_valid [MAX_DEPTH];

    dly_state_e    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dly_q, dly_d;
    logic          err_q;
    logic          restart;
    logic [DW-1:0] load_val;
    logic [WIDTH-1:0] tap_data;
    logic             tap_valid;

    assign restart  = load | flush;
    assign load_val = DW'(clamp_delay(int'(delay_sel), MAX_DEPTH));

    for (genvar g = 0; g < MAX_DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] src_data;
        logic             src_valid;
        if (g == 0) begin : g_head
            assign src_data  = in_data;
            assign src_valid = in_valid;
        end else begin : g_body
            assign src_data  = st_data[g-1];
            assign src_valid = st_valid[g-1];
        end
        dly_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .clr     (restart),
            .d_data  (src_data),
            .d_valid (src_valid),
            .q_data  (st_data[g]),
            .q_valid (st_valid[g])
        );
    end

    // Control registers: fill state, fill count, active delay, error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (DEF_D == '0) ? RUN : FILL;
            cnt_q   <= '0;
            dly_q   <= DEF_D;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            err_q   <= load && (delay_sel > MAX_D);
        end
    end

    // Next-state: load/flush restart the fill, en advances it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        if (load) begin
            dly_d   = load_val;
            cnt_d   = '0;
            state_d = (load_val == '0) ? RUN : FILL;
        end else if (flush) begin
            cnt_d   = '0;
            state_d = (dly_q == '0) ? RUN : FILL;
        end else if (en) begin
            unique case (1'b1)
                (state_q == FILL): begin
                    cnt_d = cnt_q + ONE;
                    if ((cnt_q + ONE) == dly_q) begin
                        state_d = RUN;
                    end
                end
                (state_q == RUN): begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    // Tap select: bypass at delay 0, else stage d_active-1.
    always_comb begin
        tap_data  = in_data;
        tap_valid = in_valid;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (dly_q == DW'(i + 1)) begin
                tap_data  = st_data[i];
                tap_valid = st_valid[i];
            end
        end
    end

    assign filled    = (state_q == RUN);
    assign out_data  = tap_data;
    assign out_valid = filled & tap_valid;
    assign cfg_err   = err_q;
    assign d_active  = dly_q;

endmodule

// File: tb/tb_programmable_delay_line.sv
// Self-checking bench for programmable_delay_line.
// Directed plan steps followed by random traffic vs a history model.
module tb_programmable_delay_line;

    localparam int W  = 8;
    localparam int MD = 8;
    localparam int DW = $clog2(MD + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic [DW-1:0] delay_sel;
    logic          load;
    logic          flush;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          filled;
    logic          cfg_err;
    logic [DW-1:0] d_active;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    // Model: hist[0] is the newest enabled sample, {valid,data}.
    logic [W:0] hist [MD];
    int         m_d;
    int         m_cnt;
    bit         m_err;

    programmable_delay_line #(
        .WIDTH(W),
        .MAX_DEPTH(MD),
        .DEFAULT_DELAY(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .delay_sel (delay_sel),
        .load      (load),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .filled    (filled),
        .cfg_err   (cfg_err),
        .d_active  (d_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MD; i++) hist[i] = '0;
        m_d   = 1;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic compare();
        bit         exp_fill;
        logic [W:0] tap;
        exp_fill = (m_d == 0) || (m_cnt >= m_d);
        if (m_d == 0) tap = {in_valid, in_data};
        else          tap = hist[m_d-1];
        chk("filled", 32'(filled), 32'(exp_fill));
        chk("out_valid", 32'(out_valid), 32'(exp_fill & tap[W]));
        if (exp_fill && tap[W]) chk("out_data", 32'(out_data), 32'(tap[W-1:0]));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        chk("d_active", 32'(d_active), 32'(m_d));
    endtask

    task automatic model_edge();
        bit rs;
        rs    = load || flush;
        m_err = load && (int'(delay_sel) > MD);
        if (en) begin
            for (int i = MD - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {in_valid & ~rs, in_data};
        end
        if (rs) begin
            for (int i = 0; i < MD; i++) hist[i][W] = 1'b0;
            m_cnt = 0;
            if (load) m_d = (int'(delay_sel) > MD) ? MD : int'(delay_sel);
        end else if (en && m_cnt < 1000) begin
            m_cnt++;
        end
    endtask

    // Drive at negedge, check mid-cycle, advance model at posedge.
    task automatic step(input bit e, input logic [W-1:0] d, input bit v,
                        input bit ld, input bit fl, input int sel);
        en        = e;
        in_data   = d;
        in_valid  = v;
        load      = ld;
        flush     = fl;
        delay_sel = DW'(sel);
        #1;
        compare();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_d_active"}, 32'(d_active), 32'd1);
        chk({tag, "_filled"}, 32'(filled), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        delay_sel = '0;
        load      = 1'b0;
        flush     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Default delay 1 streaming.
        for (int i = 1; i <= 8; i++) step(1, W'(i), 1, 0, 0, 0);

        // Delay 5, stream A0..AF.
        step(1, 8'hFF, 1, 1, 0, 5);
        for (int i = 0; i < 16; i++) step(1, W'(8'hA0 + i), 1, 0, 0, 0);

        // Delay 3 with en alternating.
        step(0, 8'h00, 1, 1, 0, 3);
        for (int i = 0; i < 16; i++) step(i[0] == 1'b0, W'(8'h30 + i), 1, 0, 0, 0);

        // Out-of-range load clamps to MAX_DEPTH.
        step(1, 8'h00, 1, 1, 0, MD + 3);
        chk("clamp_d_active", 32'(d_active), 32'(MD));
        chk("clamp_cfg_err", 32'(cfg_err), 32'd1);
        for (int i = 0; i < 12; i++) step(1, W'(8'h50 + i), 1, 0, 0, 0);

        // Delay 0 bypass.
        step(1, 8'h00, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, W'(8'h70 + i), i[0], 0, 0, 0);

        // Delay 4, mid-stream flush, then async reset mid-fill.
        step(1, 8'h00, 1, 1, 1, 4);
        for (int i = 0; i < 6; i++) step(1, W'(8'h80 + i), 1, 0, 0, 0);
        step(1, 8'h86, 1, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(1, W'(8'h90 + i), 1, 0, 0, 0);
        step(1, 8'h96, 1, 0, 1, 0);
        step(1, 8'h97, 1, 0, 0, 0);
        step(1, 8'h98, 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 W'($urandom_range(0, 255)),
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 24) == 0,
                 int'($urandom_range(0, (1 << DW) - 1)));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/programmable_delay_line.md
Name: programmable_delay_line

Overview:
Parametrised, runtime-programmable delay line for WIDTH-bit data with a per-sample valid qualifier, clock enable, flush and a fill-tracking controller. It delays counter or display data by 0..MAX_DEPTH enabled cycles so the two digit paths can be re-aligned. It sits between the BCD counter datapath and the seven-segment drivers. It generalises the fixed single-stage delay: configurable width and depth, a selectable tap, valid tracking and safe delay reconfiguration.

Parameters:
WIDTH, 8, data bits per sample
MAX_DEPTH, 8, number of storage stages; maximum programmable delay (>=1)
DEFAULT_DELAY, 1, delay active after reset (0..MAX_DEPTH)
DW (localparam), $clog2(MAX_DEPTH+1), width of delay fields

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  advance enable; the pipeline shifts only when en=1
in_data  input  WIDTH  sample in
in_valid  input  1  sample qualifier
delay_sel  input  DW  requested delay; sampled only when load=1
load  input  1  one-cycle strobe: apply delay_sel
flush  input  1  one-cycle strobe: invalidate contents, restart fill
out_data  output  WIDTH  delayed sample
out_valid  output  1  delayed qualifier, gated by the fill state
filled  output  1  1 when the line holds d_active fresh samples (state RUN)
cfg_err  output  1  registered one-cycle pulse: last load had delay_sel > MAX_DEPTH
d_active  output  DW  delay currently in effect

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all stage data = 0 and all stage valid = 0
  - d_active = DEFAULT_DELAY, fill_cnt = 0, cfg_err = 0
  - state = FILL, or RUN if DEFAULT_DELAY = 0
- Storage: stages s[0..MAX_DEPTH-1], each holding {valid, data}.
  - On a clock edge with en=1: s[0] <= {in_valid, in_data}; s[i] <= s[i-1].
  - en=0: all stages hold.
- Tap:
  - d_active = k >= 1: out_data = s[k-1].data and the tap valid is s[k-1].valid. This is a registered path with latency exactly k enabled cycles.
  - d_active = 0: combinational bypass. out_data = in_data and the tap valid is in_valid.
- out_valid = filled AND tap valid.
- out_data is always the tap data; it is don't-care when out_valid=0.
- FSM states: FILL, RUN.
  - FILL: on each en=1 cycle, fill_cnt++. When fill_cnt+1 == d_active on an en cycle, go to RUN at that edge. filled=0.
  - RUN: filled=1; fill_cnt saturates. Stays in RUN until load or flush.
- flush (acts regardless of en):
  - at the edge, clear all stage valid bits (data is retained)
  - fill_cnt = 0
  - state = FILL, or RUN if d_active = 0
- load (acts regardless of en):
  - at the edge, d_active = min(delay_sel, MAX_DEPTH)
  - cfg_err pulses 1 for one cycle if delay_sel > MAX_DEPTH
  - then performs the full flush action, so no duplicated or skipped samples ever appear valid
- Simultaneous load+flush: identical to load alone.
- load/flush with en=1 in the same cycle: the shift into s[0] still occurs, but s[0].valid is forced 0. fill_cnt restarts at 0, so that sample does not count.
- Load of the same delay value still flushes.
- flush/load while FILL is mid-way: fill_cnt restarts from 0.
- cfg_err is 0 in every cycle not following an out-of-range load.

Decomposition:
- Shared package dly_pkg:
  - state typedef, FILL=1'b0 / RUN=1'b1
  - a function clamping a delay to MAX_DEPTH
- One natural sub-module: dly_stage, a single {valid,data} register with enable and a valid-clear. It is instantiated MAX_DEPTH times in a generate loop.
- FSM, fill counter and tap mux stay in the top level.

Test Plan:
- Reset with DEFAULT_DELAY=1 and in_valid=1 streaming 0x01,0x02,... with en=1: filled=1 after 1 edge; out_data lags in_data by 1 cycle with out_valid=1; cfg_err=0.
- load with delay_sel=5, then stream 0xA0..0xAF:
  - out_valid=0 and filled=0 for 5 enabled cycles
  - then out_data=0xA0 with out_valid=1, following in_data by exactly 5 cycles
- en toggled 1,0,1,0 with d_active=3: stages hold on en=0 cycles; latency counts 3 enabled cycles (6 clocks). The fill counter does not advance on en=0 cycles.
- load with delay_sel=MAX_DEPTH+3:
  - d_active=MAX_DEPTH
  - cfg_err high for exactly one cycle
  - output delayed by MAX_DEPTH
- load with delay_sel=0: out_data=in_data in the same cycle; out_valid=in_valid; filled=1 the cycle after load.
- Mid-stream flush at d_active=4, then rst_n pulsed low asynchronously mid-FILL:
  - after flush: out_valid=0 for 4 enabled cycles, then resumes
  - rst_n=0: all outputs return immediately to their reset values without a clock edge
